findext_fsm: RTL and testbench
==============================

FINDEXT_FSM -- requirements
Module: findext_fsm

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8: sample width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 16: samples per frame, with DEPTH >= 2.
REQ-003 The module SHALL have localparam IDXW = $clog2(DEPTH): index width.
REQ-004 The module SHALL have port clk  in  1: single clock; all state updates occur on its rising edge.
REQ-005 The module SHALL have port reset_n  in  1: reset, asynchronous, active-low.
REQ-006 The module SHALL have port start  in  1: begin a frame; honoured only in IDLE or DONE.
REQ-007 The module SHALL have port abort  in  1: cancel the frame in progress.
REQ-008 The module SHALL have port is_signed  in  1: compare mode (1 = two's complement, 0 = unsigned), sampled when start is accepted.
REQ-009 The module SHALL have port in_valid  in  1: in_data is valid.
REQ-010 The module SHALL have port in_data  in  WIDTH: sample.
REQ-011 The module SHALL have port in_ready  out  1: the block accepts a sample this cycle.
REQ-012 The module SHALL have ports busy  out  1 (frame in progress) and done  out  1 (results valid).
REQ-013 The module SHALL have ports max_val, min_val  out  WIDTH: frame extrema.
REQ-014 The module SHALL have ports max_idx, min_idx  out  IDXW: sample positions of the extrema.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
REQ-016 In IDLE, start SHALL cause a transition to ACCUM, latch is_signed into mode_q, and clear the sample count to 0.
REQ-017 In ACCUM, in_ready SHALL be 1 and busy SHALL be 1; in IDLE and DONE, both SHALL be 0.
REQ-018 An accept SHALL occur when in_valid and in_ready are both 1; samples with in_valid=0 SHALL be ignored and the count SHALL NOT advance.
REQ-019 On the accept at count 0, the block SHALL set max_val and min_val to in_data and max_idx and min_idx to 0, unconditionally.
REQ-020 On an accept at count k>0, if in_data > max_val (strict) under mode_q, the block SHALL set max_val to in_data and max_idx to k.
REQ-021 On an accept at count k>0, if in_data < min_val (strict), the block SHALL set min_val to in_data and min_idx to k.
REQ-022 On ties, the block SHALL retain the earliest index.
REQ-023 Result registers SHALL update on the clock edge of the accept, giving one cycle of latency.
REQ-024 The accept at count DEPTH-1 SHALL cause a transition to DONE; done SHALL rise in the following cycle and hold while in DONE.
REQ-025 The count SHALL NOT wrap.
REQ-026 In DONE, results SHALL be stable; start SHALL clear done and re-enter ACCUM with a new mode latch.
REQ-027 Old results SHALL remain visible until the first accept of the new frame.
REQ-028 start SHALL be ignored in ACCUM.
REQ-029 abort in ACCUM SHALL cause a transition to IDLE and clear done.
REQ-030 A sample accepted in the same cycle as abort SHALL be discarded.
REQ-031 Result registers SHALL keep their last values after abort, and their contents SHALL be undefined for use.
REQ-032 abort SHALL have priority over start; abort in IDLE or DONE SHALL be ignored.
REQ-033 In signed mode, comparisons SHALL treat operands as WIDTH-bit two's complement; in unsigned mode, as unsigned.

Reset
REQ-034 While reset_n=0, the FSM SHALL be in IDLE, and count, mode_q, done, busy, in_ready, max_val, min_val, max_idx and min_idx SHALL all be 0.
REQ-035 Reset asserted mid-frame SHALL discard the frame immediately, without waiting for a clock edge.
REQ-036 After reset deassertion, the first start SHALL be honoured in the next clock cycle.

Structure
REQ-037 Package findext_pkg SHALL hold the state enum (IDLE, ACCUM, DONE) and the defaults for WIDTH and DEPTH.
REQ-038 The module SHALL instantiate two instances of sub-module mode_cmp: one comparing in_data against max_val, one against min_val.
REQ-039 mode_cmp SHALL be a parametrised WIDTH comparator with a signed/unsigned mode input and lt/eq/gt outputs.
REQ-040 The FSM and datapath SHALL reside in findext_fsm.

Verification
REQ-041 The bench SHALL cover: unsigned, DEPTH=4, samples 3,9,1,9 contiguous -> done one cycle after the 4th accept; max_val=9, max_idx=1, min_val=1, min_idx=2.
REQ-042 The bench SHALL cover: signed, WIDTH=8, samples 0x7F,0x80,0x01,0xFF -> max_val=0x7F (idx 0), min_val=0x80 (idx 1); the same data in unsigned mode -> max_val=0xFF (idx 3), min_val=0x01 (idx 2).
REQ-043 The bench SHALL cover: in_valid toggling 1,0,0,1,1,0,1 with DEPTH=4 -> exactly 4 accepts, count holds during gaps, done after the 4th accept.
REQ-044 The bench SHALL cover: abort after 2 accepts, with a valid sample in the abort cycle -> IDLE next cycle, busy=0, done=0; a new start then yields results from the new frame only.
REQ-045 The bench SHALL cover: reset_n pulled low asynchronously (between clock edges) mid-frame -> all outputs 0 before the next clk edge; start while in ACCUM -> ignored, frame completes normally.
REQ-046 The bench SHALL cover: all-equal frame (DEPTH x 0x55) -> max_idx=min_idx=0.

Source files
------------

// File: rtl/findext_pkg.sv
// Shared definitions for the frame-extrema finder: FSM state type and
// default geometry.
package findext_pkg;

  localparam int unsigned FINDEXT_WIDTH = 8;
  localparam int unsigned FINDEXT_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/findext_fsm_cmp.sv
// Magnitude comparator whose operands are read as two's complement or
// unsigned depending on is_signed.
module mode_cmp #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  always_comb begin
    eq = (a == b);
    if (is_signed) lt = ($signed(a) < $signed(b));
    else           lt = (a < b);
    gt = !lt && !eq;
  end

endmodule

// File: rtl/findext_fsm.sv
// Streams DEPTH samples per frame and reports the max/min values with the
// index of their first occurrence.
module findext_fsm
  import findext_pkg::*;
#(
  parameter  int unsigned WIDTH = FINDEXT_WIDTH,
  parameter  int unsigned DEPTH = FINDEXT_DEPTH,
  localparam int unsigned IDXW  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic             is_signed,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] min_val,
  output logic [IDXW-1:0]  max_idx,
  output logic [IDXW-1:0]  min_idx
);

  localparam logic [IDXW-1:0] LAST = IDXW'(DEPTH - 1);

  state_t           r_state;
  logic [IDXW-1:0]  r_count;
  logic             r_mode;
  logic [WIDTH-1:0] r_max_val;
  logic [WIDTH-1:0] r_min_val;
  logic [IDXW-1:0]  r_max_idx;
  logic [IDXW-1:0]  r_min_idx;

  logic w_accept;
  logic w_max_gt;
  logic w_min_lt;
  logic w_max_lt_unused, w_max_eq_unused;
  logic w_min_eq_unused, w_min_gt_unused;

  mode_cmp #(.WIDTH(WIDTH)) u_cmp_max (
    .a         (in_data),
    .b         (r_max_val),
    .is_signed (r_mode),
    .lt        (w_max_lt_unused),
    .eq        (w_max_eq_unused),
    .gt        (w_max_gt)
  );

  mode_cmp #(.WIDTH(WIDTH)) u_cmp_min (
    .a         (in_data),
    .b         (r_min_val),
    .is_signed (r_mode),
    .lt        (w_min_lt),
    .eq        (w_min_eq_unused),
    .gt        (w_min_gt_unused)
  );

  assign w_accept = in_valid && (r_state == ACCUM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_mode    <= 1'b0;
      r_max_val <= '0;
      r_min_val <= '0;
      r_max_idx <= '0;
      r_min_idx <= '0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state <= ACCUM;
            r_mode  <= is_signed;
            r_count <= '0;
          end
        end
        ACCUM: begin
          // abort wins: the sample presented alongside it is dropped
          if (abort) begin
            r_state <= IDLE;
          end else if (w_accept) begin
            if (r_count == '0) begin
              r_max_val <= in_data;
              r_min_val <= in_data;
              r_max_idx <= '0;
              r_min_idx <= '0;
            end else begin
              if (w_max_gt) begin
                r_max_val <= in_data;
                r_max_idx <= r_count;
              end
              if (w_min_lt) begin
                r_min_val <= in_data;
                r_min_idx <= r_count;
              end
            end
            if (r_count == LAST) r_state <= DONE;
            else                 r_count <= r_count + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = (r_state == ACCUM);
  assign in_ready = (r_state == ACCUM);
  assign done     = (r_state == DONE);
  assign max_val  = r_max_val;
  assign min_val  = r_min_val;
  assign max_idx  = r_max_idx;
  assign min_idx  = r_min_idx;

endmodule

// File: tb/tb_findext_fsm.sv
// Self-checking bench for findext_fsm: directed vector table, hand-written
// abort/reset sequences, and randomized traffic against a queue-based model.
module tb_findext_fsm;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;
  localparam int unsigned IW = $clog2(D);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, abort, is_signed, in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready, busy, done;
  logic [W-1:0]  max_val, min_val;
  logic [IW-1:0] max_idx, min_idx;

  int n_vec = 0;
  int n_err = 0;

  findext_fsm #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .is_signed (is_signed),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .busy      (busy),
    .done      (done),
    .max_val   (max_val),
    .min_val   (min_val),
    .max_idx   (max_idx),
    .min_idx   (min_idx)
  );

  always #5 clk = ~clk;

  // Reference model: frame contents kept as a queue, extrema recomputed
  // from the whole queue by value ordering.
  bit           m_busy, m_done, m_mode;
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_max, m_min;
  logic [IW-1:0] m_maxi, m_mini;

  function automatic int key(logic [W-1:0] v);
    if (m_mode) return int'($signed(v));
    return int'({24'b0, v});
  endfunction

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_mode = 0; m_q.delete();
    m_max = '0; m_min = '0; m_maxi = '0; m_mini = '0;
  endtask

  task automatic model_extrema();
    int best_hi, best_lo;
    best_hi = 0; best_lo = 0;
    foreach (m_q[i]) begin
      if (key(m_q[i]) > key(m_q[best_hi])) best_hi = i;
      if (key(m_q[i]) < key(m_q[best_lo])) best_lo = i;
    end
    m_max = m_q[best_hi]; m_maxi = IW'(best_hi);
    m_min = m_q[best_lo]; m_mini = IW'(best_lo);
  endtask

  task automatic model_step(bit st, bit ab, bit sg, bit v, logic [W-1:0] d);
    if (m_busy) begin
      if (ab) begin
        m_busy = 0; m_done = 0;
      end else if (v) begin
        m_q.push_back(d);
        model_extrema();
        if (m_q.size() == D) begin m_busy = 0; m_done = 1; end
      end
    end else if (st) begin
      m_busy = 1; m_done = 0; m_mode = sg; m_q.delete();
    end
  endtask

  task automatic check_model(string name);
    n_vec++;
    if (busy !== m_busy || in_ready !== m_busy || done !== m_done ||
        max_val !== m_max || max_idx !== m_maxi ||
        min_val !== m_min || min_idx !== m_mini) begin
      n_err++;
      $display("FAIL %s: got busy=%b rdy=%b done=%b max=%h@%0d min=%h@%0d, want busy=%b rdy=%b done=%b max=%h@%0d min=%h@%0d",
               name, busy, in_ready, done, max_val, max_idx, min_val, min_idx,
               m_busy, m_busy, m_done, m_max, m_maxi, m_min, m_mini);
    end
  endtask

  task automatic check_exp(string name, bit eb, bit ed, logic [W-1:0] emax,
                           logic [IW-1:0] emaxi, logic [W-1:0] emin, logic [IW-1:0] emini);
    n_vec++;
    if (busy !== eb || in_ready !== eb || done !== ed || max_val !== emax ||
        max_idx !== emaxi || min_val !== emin || min_idx !== emini) begin
      n_err++;
      $display("FAIL %s: got busy=%b rdy=%b done=%b max=%h@%0d min=%h@%0d, want busy=%b rdy=%b done=%b max=%h@%0d min=%h@%0d",
               name, busy, in_ready, done, max_val, max_idx, min_val, min_idx,
               eb, eb, ed, emax, emaxi, emin, emini);
    end
  endtask

  task automatic apply(string name, bit st, bit ab, bit sg, bit v, logic [W-1:0] d);
    start = st; abort = ab; is_signed = sg; in_valid = v; in_data = d;
    @(posedge clk);
    #1;
    model_step(st, ab, sg, v, d);
    check_model(name);
    start = 0; abort = 0; in_valid = 0;
  endtask

  typedef struct {
    bit st; bit sg; bit v; logic [W-1:0] d;
    bit eb; bit ed;
    logic [W-1:0] emax; logic [IW-1:0] emaxi;
    logic [W-1:0] emin; logic [IW-1:0] emini;
  } vec_t;

  function automatic vec_t mk(bit st, bit sg, bit v, logic [W-1:0] d, bit eb, bit ed,
                              logic [W-1:0] emax, logic [IW-1:0] emaxi,
                              logic [W-1:0] emin, logic [IW-1:0] emini);
    vec_t r;
    r.st = st; r.sg = sg; r.v = v; r.d = d; r.eb = eb; r.ed = ed;
    r.emax = emax; r.emaxi = emaxi; r.emin = emin; r.emini = emini;
    return r;
  endfunction

  vec_t tbl[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // unsigned 3,9,1,9
    tbl.push_back(mk(1,0,0,8'h00, 1,0, 8'h00,0, 8'h00,0));
    tbl.push_back(mk(0,0,1,8'h03, 1,0, 8'h03,0, 8'h03,0));
    tbl.push_back(mk(0,0,1,8'h09, 1,0, 8'h09,1, 8'h03,0));
    tbl.push_back(mk(0,0,1,8'h01, 1,0, 8'h09,1, 8'h01,2));
    tbl.push_back(mk(0,0,1,8'h09, 0,1, 8'h09,1, 8'h01,2));
    // signed 7F,80,01,FF; old results persist until first accept
    tbl.push_back(mk(1,1,0,8'h00, 1,0, 8'h09,1, 8'h01,2));
    tbl.push_back(mk(0,0,1,8'h7F, 1,0, 8'h7F,0, 8'h7F,0));
    tbl.push_back(mk(0,0,1,8'h80, 1,0, 8'h7F,0, 8'h80,1));
    tbl.push_back(mk(0,0,1,8'h01, 1,0, 8'h7F,0, 8'h80,1));
    tbl.push_back(mk(0,0,1,8'hFF, 0,1, 8'h7F,0, 8'h80,1));
    // same data unsigned
    tbl.push_back(mk(1,0,0,8'h00, 1,0, 8'h7F,0, 8'h80,1));
    tbl.push_back(mk(0,0,1,8'h7F, 1,0, 8'h7F,0, 8'h7F,0));
    tbl.push_back(mk(0,0,1,8'h80, 1,0, 8'h80,1, 8'h7F,0));
    tbl.push_back(mk(0,0,1,8'h01, 1,0, 8'h80,1, 8'h01,2));
    tbl.push_back(mk(0,0,1,8'hFF, 0,1, 8'hFF,3, 8'h01,2));
    // in_valid pattern 1,0,0,1,1,0,1
    tbl.push_back(mk(1,0,0,8'h00, 1,0, 8'hFF,3, 8'h01,2));
    tbl.push_back(mk(0,0,1,8'h10, 1,0, 8'h10,0, 8'h10,0));
    tbl.push_back(mk(0,0,0,8'hEE, 1,0, 8'h10,0, 8'h10,0));
    tbl.push_back(mk(0,0,0,8'h00, 1,0, 8'h10,0, 8'h10,0));
    tbl.push_back(mk(0,0,1,8'h20, 1,0, 8'h20,1, 8'h10,0));
    tbl.push_back(mk(0,0,1,8'h05, 1,0, 8'h20,1, 8'h05,2));
    tbl.push_back(mk(0,0,0,8'hFF, 1,0, 8'h20,1, 8'h05,2));
    tbl.push_back(mk(0,0,1,8'h30, 0,1, 8'h30,3, 8'h05,2));
    // all-equal frame
    tbl.push_back(mk(1,0,0,8'h00, 1,0, 8'h30,3, 8'h05,2));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,1,8'h55, 1,0, 8'h55,0, 8'h55,0));
    tbl.push_back(mk(0,0,1,8'h55, 0,1, 8'h55,0, 8'h55,0));
    // start (signed) during ACCUM must not change the latched unsigned mode
    tbl.push_back(mk(1,0,0,8'h00, 1,0, 8'h55,0, 8'h55,0));
    tbl.push_back(mk(1,1,1,8'h80, 1,0, 8'h80,0, 8'h80,0));
    tbl.push_back(mk(1,1,1,8'h01, 1,0, 8'h80,0, 8'h01,1));
    tbl.push_back(mk(1,1,1,8'h02, 1,0, 8'h80,0, 8'h01,1));
    tbl.push_back(mk(0,0,1,8'h03, 0,1, 8'h80,0, 8'h01,1));

    start = 0; abort = 0; is_signed = 0; in_valid = 0; in_data = '0;
    reset_n = 0;
    model_reset();
    #1;
    check_exp("reset_state", 0,0, 8'h00,0, 8'h00,0);
    #11 reset_n = 1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      apply($sformatf("tbl%0d_model", i), tbl[i].st, 1'b0, tbl[i].sg, tbl[i].v, tbl[i].d);
      check_exp($sformatf("tbl%0d", i), tbl[i].eb, tbl[i].ed,
                tbl[i].emax, tbl[i].emaxi, tbl[i].emin, tbl[i].emini);
    end

    // abort after two accepts with a valid sample in the abort cycle
    apply("ab_start", 1,0,0,0,8'h00);
    apply("ab_s0",    0,0,0,1,8'h40);
    apply("ab_s1",    0,0,0,1,8'h41);
    apply("ab_abort", 0,1,0,1,8'h01);
    check_exp("abort_idle", 0,0, 8'h41,1, 8'h40,0);
    apply("ab_restart", 1,0,0,0,8'h00);
    for (int i = 0; i < 4; i++) apply("ab_new", 0,0,0,1, 8'h90 + 8'(i));
    check_exp("after_abort_frame", 0,1, 8'h93,3, 8'h90,0);
    apply("abort_in_done", 0,1,0,0,8'h00);
    check_exp("abort_in_done_ignored", 0,1, 8'h93,3, 8'h90,0);

    // asynchronous reset mid-frame, between clock edges
    apply("rs_start", 1,0,1,0,8'h00);
    apply("rs_s0",    0,0,0,1,8'hC3);
    apply("rs_s1",    0,0,0,1,8'h12);
    in_valid = 1; in_data = 8'h77;
    @(negedge clk); #2;
    reset_n = 0;
    #1;
    model_reset();
    check_exp("async_reset_zero", 0,0, 8'h00,0, 8'h00,0);
    in_valid = 0;
    @(posedge clk); #1;
    check_exp("reset_held", 0,0, 8'h00,0, 8'h00,0);
    @(negedge clk);
    reset_n = 1;
    apply("first_start_after_reset", 1,0,0,0,8'h00);
    check_exp("start_honoured", 1,0, 8'h00,0, 8'h00,0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit st, ab, sg, v;
      logic [W-1:0] d;
      st = ($urandom_range(0, 7) == 0);
      ab = !st && ($urandom_range(0, 19) == 0);
      sg = 1'($urandom);
      v  = ($urandom_range(0, 3) != 0);
      d  = 8'($urandom);
      if ($urandom_range(0, 4) == 0) d = {$urandom_range(0, 1) == 1 ? 8'h80 : 8'h7F};
      apply($sformatf("rand%0d", i), st, ab, sg, v, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
